ifetch: RTL
===========

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_ADDR, default `RESET_ADDR` (32'h0000_0000), first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, prefetch buffer entries; only 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 hold_flag_i  input  1  downstream stall; while high, the instruction register does not consume.
REQ-006 jump_flag_i  input  1  redirect request from execute.
REQ-007 jump_addr_i  input  32  redirect target.
REQ-008 ibus_req_o  output  1  fetch request to instruction memory.
REQ-009 ibus_addr_o  output  32  fetch address; bits [1:0] are always 0.
REQ-010 ibus_gnt_i  input  1  memory accepts the request in the cycle where req and gnt are both high.
REQ-011 ibus_rvalid_i  input  1  read data valid, earliest one cycle after grant.
REQ-012 ibus_rdata_i  input  32  fetched instruction.
REQ-013 ins_o  output  32  instruction to the instruction register; `INS_NOP` (32'h0000_0013) when ins_valid_o=0.
REQ-014 ins_addr_o  output  32  address of ins_o; RESET_ADDR when ins_valid_o=0.
REQ-015 ins_valid_o  output  1  FIFO head is valid.

Function
REQ-016 The FSM SHALL have three states: REQ (may issue), WAIT (one request granted, awaiting rvalid), and DROP (the awaited response is stale and is discarded).
REQ-017 At most one request SHALL be outstanding.
REQ-018 In REQ, ibus_req_o=1 iff (fifo_count < 2) and jump_flag_i=0, with ibus_addr_o=pc.
REQ-019 REQ with req&gnt SHALL cause pc<=pc+4 (mod 2^32: 32'hFFFF_FFFC wraps to 0), record the request address as the tag, and go to WAIT.
REQ-020 WAIT with rvalid and no jump SHALL push {tag, rdata} into the FIFO and go to REQ; no new request is issued in that same cycle.
REQ-021 Pop SHALL occur when ins_valid_o=1, hold_flag_i=0 and jump_flag_i=0.
REQ-022 Push and pop SHALL both be allowed in the same cycle.
REQ-023 The FIFO SHALL never overflow, since a grant needs fifo_count<2 with no outstanding request.
REQ-024 ins_o, ins_addr_o and ins_valid_o SHALL be driven combinationally from the FIFO head.
REQ-025 While hold_flag_i=1, the head SHALL be held stable.
REQ-026 jump_flag_i=1 SHALL, in the same edge: flush the FIFO (count=0) and set pc<={jump_addr_i[31:2],2'b00}.
REQ-027 On a jump, REQ stays REQ.
REQ-028 On a jump, WAIT with rvalid SHALL discard the data and go to REQ.
REQ-029 On a jump, WAIT without rvalid SHALL go to DROP.
REQ-030 DROP SHALL discard the next rvalid and then go to REQ.
REQ-031 A jump in DROP SHALL update pc and stay in DROP; a jump overrides a simultaneous pop or push.
REQ-032 In REQ, an rvalid with nothing outstanding SHALL be ignored.
REQ-033 In REQ with hold_flag_i=1, prefetch SHALL continue until the FIFO is full.
REQ-034 With gnt=1 and rvalid=1 every cycle, throughput SHALL be one instruction per 2 cycles.

Reset
REQ-035 rst=1 SHALL immediately set: state=REQ, pc=RESET_ADDR, fifo_count=0, tag=RESET_ADDR.
REQ-036 During reset, ibus_req_o=0, ins_valid_o=0, ins_o=`INS_NOP` and ins_addr_o=RESET_ADDR.
REQ-037 The first request SHALL be issued in the first cycle after rst deasserts.
REQ-038 A response to a request made before reset SHALL be ignored (covered by REQ-032).

Structure
REQ-039 `INS_NOP`, `RESET_ADDR`, `INST_DATA_BUS` and `INST_ADDR_BUS` SHALL come from the shared defines.v.
REQ-040 The FSM state encodings SHALL be local constants.
REQ-041 The prefetch buffer SHALL be the sub-module ifetch_fifo: 2 entries x 64 bits, with push, pop, flush, count and head outputs, and asynchronous active-high reset.

Verification
REQ-042 Reset release with gnt=1 and rvalid one cycle later -> req at 0x0, then 0x4; ins_valid_o rises with ins_addr_o=0x0 and ins_o=rdata.
REQ-043 hold_flag_i=1 held for 10 cycles -> exactly 2 grants (0x0, 0x4), then ibus_req_o=0; the head stays 0x0 until hold drops.
REQ-044 Jump to 0x103 while in WAIT, rvalid two cycles later -> that data is not pushed, FIFO is empty, and the next request address is 0x100.
REQ-045 Jump in the same cycle as rvalid -> data discarded; next cycle req with the jump address; no DROP entered.
REQ-046 pc=0xFFFF_FFFC granted -> next request address is 0x0000_0000.
REQ-047 rst asserted in WAIT, then a stray rvalid after release -> ins_valid_o stays 0 and the first request is at RESET_ADDR.

Source files
------------

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared bus widths, instruction constants and prefetch entry type
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam int          c_INST_ADDR_BUS = 32;
    localparam int          c_INST_DATA_BUS = 32;
    localparam logic [31:0] c_INS_NOP       = 32'h0000_0013;
    localparam logic [31:0] c_RESET_ADDR    = 32'h0000_0000;

    typedef struct packed {
        logic [c_INST_ADDR_BUS-1:0] addr;
        logic [c_INST_DATA_BUS-1:0] ins;
    } fetch_entry_t;

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/ifetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_if
// Description : Fetch-unit control, instruction bus and instruction-register port
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_if;
    import ifetch_pkg::*;

    logic                       hold_flag_i;
    logic                       jump_flag_i;
    logic [c_INST_ADDR_BUS-1:0] jump_addr_i;
    logic                       ibus_req_o;
    logic [c_INST_ADDR_BUS-1:0] ibus_addr_o;
    logic                       ibus_gnt_i;
    logic                       ibus_rvalid_i;
    logic [c_INST_DATA_BUS-1:0] ibus_rdata_i;
    logic [c_INST_DATA_BUS-1:0] ins_o;
    logic [c_INST_ADDR_BUS-1:0] ins_addr_o;
    logic                       ins_valid_o;

    modport master (
        input  hold_flag_i, jump_flag_i, jump_addr_i,
        input  ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i,
        output ibus_req_o, ibus_addr_o,
        output ins_o, ins_addr_o, ins_valid_o
    );

    modport slave (
        output hold_flag_i, jump_flag_i, jump_addr_i,
        output ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i,
        input  ibus_req_o, ibus_addr_o,
        input  ins_o, ins_addr_o, ins_valid_o
    );

endinterface : ifetch_if
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_fifo
// Description : Two-entry prefetch buffer of {address, instruction} pairs
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo
    import ifetch_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         flush,
    input  wire logic         push,
    input  wire fetch_entry_t push_data,
    input  wire logic         pop,
    output logic [1:0]        count,
    output fetch_entry_t      head,
    output logic              head_valid
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_do_pop;
    logic         w_do_push;

    assign w_do_pop  = pop && (r_count != 2'd0);
    // a full buffer may still accept a push when its head leaves in the same cycle
    assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign count      = r_count;
    assign head       = r_mem[r_rd_ptr];
    assign head_valid = (r_count != 2'd0);

endmodule : ifetch_fifo
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module      : ifetch
// Description : Instruction fetch with one outstanding request and 2-deep prefetch
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = c_RESET_ADDR,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    ifetch_if.master  bus
);

    localparam logic [1:0] c_S_REQ     = 2'd0;
    localparam logic [1:0] c_S_WAIT    = 2'd1;
    localparam logic [1:0] c_S_DROP    = 2'd2;
    localparam logic [1:0] c_FIFO_FULL = FIFO_DEPTH[1:0];

    logic [1:0]                 r_state;
    logic [c_INST_ADDR_BUS-1:0] r_pc;
    logic [c_INST_ADDR_BUS-1:0] r_tag;

    logic [1:0]                 w_count;
    fetch_entry_t               w_head;
    logic                       w_head_valid;
    logic                       w_req;
    logic                       w_grant;
    logic                       w_push;
    logic                       w_pop;
    logic [c_INST_ADDR_BUS-1:0] w_jump_target;
    fetch_entry_t               w_push_data;

    assign w_jump_target = bus.jump_addr_i & ~32'h0000_0003;

    // request is gated by rst so the bus stays quiet while reset is held
    assign w_req   = !rst && (r_state == c_S_REQ) && (w_count < c_FIFO_FULL)
                     && !bus.jump_flag_i;
    assign w_grant = w_req && bus.ibus_gnt_i;
    assign w_push  = (r_state == c_S_WAIT) && bus.ibus_rvalid_i && !bus.jump_flag_i;
    assign w_pop   = w_head_valid && !bus.hold_flag_i && !bus.jump_flag_i;

    assign w_push_data.addr = r_tag;
    assign w_push_data.ins  = bus.ibus_rdata_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_REQ;
            r_pc    <= RESET_ADDR;
            r_tag   <= RESET_ADDR;
        end else begin
            case (r_state)
                c_S_REQ: begin
                    if (bus.jump_flag_i) begin
                        r_pc <= w_jump_target;
                    end else if (w_grant) begin
                        r_pc    <= r_pc + 32'd4;
                        r_tag   <= r_pc;
                        r_state <= c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    if (bus.jump_flag_i) begin
                        r_pc    <= w_jump_target;
                        r_state <= bus.ibus_rvalid_i ? c_S_REQ : c_S_DROP;
                    end else if (bus.ibus_rvalid_i) begin
                        r_state <= c_S_REQ;
                    end
                end
                c_S_DROP: begin
                    // the stale response retires the outstanding request even on a jump
                    if (bus.jump_flag_i)    r_pc    <= w_jump_target;
                    if (bus.ibus_rvalid_i)  r_state <= c_S_REQ;
                end
                default: r_state <= c_S_REQ;
            endcase
        end
    end

    ifetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.jump_flag_i),
        .push       (w_push),
        .push_data  (w_push_data),
        .pop        (w_pop),
        .count      (w_count),
        .head       (w_head),
        .head_valid (w_head_valid)
    );

    assign bus.ibus_req_o  = w_req;
    assign bus.ibus_addr_o = r_pc;
    assign bus.ins_valid_o = w_head_valid;
    assign bus.ins_o       = w_head_valid ? w_head.ins  : c_INS_NOP;
    assign bus.ins_addr_o  = w_head_valid ? w_head.addr : RESET_ADDR;

endmodule : ifetch
`default_nettype wire
